// File: rtl/weight_sram_responder.sv
// ---------------------------------------------------------------------------
// weight_sram_responder
//
// Weight store for the convolution coprocessor. The host fills the SRAM
// one word at a time; the coprocessor then fetches weights, or asks how
// many kernels (ofmaps) and pixels per kernel have been loaded. Every
// read-class request gets exactly one response one cycle later.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous reset, active low
//   enableWSRAM  qualifies every request strobe below
//   writeWSRAM   host write strobe (highest priority)
//   readWSRAM    weight read request
//   readWifmaps  request for the loaded kernel count
//   readWpixels  request for the loaded pixels-per-kernel count
//   WkernAddr    kernel address
//   WpixAddr     pixel address within the kernel
//   hostData     write data
//   weightOut    response data, held between responses
//   weightValid  one-cycle pulse: weightOut carries a weight or a count
//   readErr      one-cycle pulse: the weight read fell outside the extent
// ---------------------------------------------------------------------------
module weight_sram_responder #(
  parameter int KERN_AW = 4,
  parameter int PIX_AW  = 6,
  parameter int DATA_W  = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enableWSRAM,
  input  logic               writeWSRAM,
  input  logic               readWSRAM,
  input  logic               readWifmaps,
  input  logic               readWpixels,
  input  logic [KERN_AW-1:0] WkernAddr,
  input  logic [PIX_AW-1:0]  WpixAddr,
  input  logic [DATA_W-1:0]  hostData,
  output logic [DATA_W-1:0]  weightOut,
  output logic               weightValid,
  output logic               readErr
);

  localparam int DEPTH = 1 << (KERN_AW + PIX_AW);

  typedef enum logic [1:0] {
    IDLE,
    RESP_W,
    RESP_H,
    RESP_E
  } RespState;

  RespState state;
  RespState nextState;

  logic [DATA_W-1:0]         mem [DEPTH];
  logic [KERN_AW+PIX_AW-1:0] wordAddr;
  logic [7:0]                numMaps;
  logic [7:0]                numPix;
  logic [7:0]                kernExtent;
  logic [7:0]                pixExtent;
  logic                      outOfExtent;
  logic                      doWrite;
  logic [DATA_W-1:0]         nextOut;

  assign wordAddr = {WkernAddr, WpixAddr};

  // The extents are computed in 8 bits so that the top address plus one
  // (16 kernels, 64 pixels) does not wrap back to zero.
  assign kernExtent  = 8'(WkernAddr) + 8'd1;
  assign pixExtent   = 8'(WpixAddr) + 8'd1;
  assign outOfExtent = (8'(WkernAddr) >= numMaps) || (8'(WpixAddr) >= numPix);

  // A write issued in a reset cycle is discarded like any other request.
  assign doWrite = reset && enableWSRAM && writeWSRAM;

  // Storage array. It is deliberately left out of reset so that it maps onto
  // a plain SRAM macro; the extent registers keep stale words from being
  // returned after a reset.
  always_ff @(posedge clock) begin
    if (doWrite) begin
      mem[wordAddr] <= hostData;
    end
  end

  // Extent tracking: each write grows numMaps/numPix to cover the written
  // address, and they never shrink until the next reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      numMaps <= 8'd0;
      numPix  <= 8'd0;
    end else if (doWrite) begin
      if (kernExtent > numMaps) begin
        numMaps <= kernExtent;
      end
      if (pixExtent > numPix) begin
        numPix <= pixExtent;
      end
    end
  end

  // Request decode in strict priority order. A write swallows any read
  // strobe raised with it, and lower-priority reads are dropped rather than
  // queued. The array is read combinationally here and captured at the edge,
  // so a word written on the previous edge is already visible.
  always_comb begin
    nextState = IDLE;
    nextOut   = weightOut;
    if (enableWSRAM && !writeWSRAM) begin
      if (readWSRAM) begin
        if (outOfExtent) begin
          nextState = RESP_E;
          nextOut   = '0;
        end else begin
          nextState = RESP_W;
          nextOut   = mem[wordAddr];
        end
      end else if (readWifmaps) begin
        nextState = RESP_H;
        nextOut   = DATA_W'(numMaps);
      end else if (readWpixels) begin
        nextState = RESP_H;
        nextOut   = DATA_W'(numPix);
      end
    end
  end

  // Response register. Each response state lasts one cycle because the
  // next state is recomputed from the strobes every cycle; reset also kills
  // any response that was about to be issued.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      weightOut <= '0;
    end else begin
      state     <= nextState;
      weightOut <= nextOut;
    end
  end

  // The pulses are decoded straight from the state, so valid and error can
  // never be high together.
  assign weightValid = (state == RESP_W) || (state == RESP_H);
  assign readErr     = (state == RESP_E);

endmodule

// File: tb/tb_weight_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_weight_sram_responder
//
// Drives weight_sram_responder with directed scenarios followed by random
// traffic. A behavioural model (array of words, written-flags and two
// integer extents) predicts every response, which is compared one cycle
// after each request.
// ---------------------------------------------------------------------------
module tb_weight_sram_responder;

  logic       clock;
  logic       reset;
  logic       enableWSRAM;
  logic       writeWSRAM;
  logic       readWSRAM;
  logic       readWifmaps;
  logic       readWpixels;
  logic [3:0] WkernAddr;
  logic [5:0] WpixAddr;
  logic [7:0] hostData;
  logic [7:0] weightOut;
  logic       weightValid;
  logic       readErr;

  int checks = 0;
  int errors = 0;

  logic [7:0] refMem [1024];
  bit         refWritten [1024];
  int         refMaps;
  int         refPix;
  logic [7:0] expOut;
  bit         expOutKnown;
  bit         expValid;
  bit         expErr;

  weight_sram_responder #(
    .KERN_AW(4),
    .PIX_AW (6),
    .DATA_W (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enableWSRAM(enableWSRAM),
    .writeWSRAM (writeWSRAM),
    .readWSRAM  (readWSRAM),
    .readWifmaps(readWifmaps),
    .readWpixels(readWpixels),
    .WkernAddr  (WkernAddr),
    .WpixAddr   (WpixAddr),
    .hostData   (hostData),
    .weightOut  (weightOut),
    .weightValid(weightValid),
    .readErr    (readErr)
  );

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard time limit so a stuck run still ends with a report.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, predicts the response from the model, lets
  // the edge happen and checks the outputs 1 ns later. Returns 1 ns after
  // the edge so consecutive calls produce back-to-back requests.
  task automatic applyStimulus(input bit rst, input bit en, input bit wr,
                               input bit rd, input bit rm, input bit rp,
                               input int kern, input int pix, input int data);
    int addr;
    reset       = ~rst;
    enableWSRAM = en;
    writeWSRAM  = wr;
    readWSRAM   = rd;
    readWifmaps = rm;
    readWpixels = rp;
    WkernAddr   = 4'(kern);
    WpixAddr    = 6'(pix);
    hostData    = 8'(data);
    addr        = (kern % 16) * 64 + (pix % 64);

    expValid = 0;
    expErr   = 0;
    if (rst) begin
      expOut      = 8'd0;
      expOutKnown = 1;
      refMaps     = 0;
      refPix      = 0;
    end else if (en) begin
      if (wr) begin
        refMem[addr]     = 8'(data);
        refWritten[addr] = 1;
        if ((kern % 16) + 1 > refMaps) refMaps = (kern % 16) + 1;
        if ((pix % 64) + 1 > refPix) refPix = (pix % 64) + 1;
      end else if (rd) begin
        if ((kern % 16) >= refMaps || (pix % 64) >= refPix) begin
          expErr      = 1;
          expOut      = 8'd0;
          expOutKnown = 1;
        end else begin
          expValid    = 1;
          expOut      = refMem[addr];
          expOutKnown = refWritten[addr];
        end
      end else if (rm) begin
        expValid    = 1;
        expOut      = 8'(refMaps);
        expOutKnown = 1;
      end else if (rp) begin
        expValid    = 1;
        expOut      = 8'(refPix);
        expOutKnown = 1;
      end
    end

    @(posedge clock);
    #1;
    checkOutput("weightValid", 32'(weightValid), 32'(expValid));
    checkOutput("readErr", 32'(readErr), 32'(expErr));
    checkOutput("pulseExclusive", 32'(weightValid & readErr), 32'd0);
    if (expOutKnown) begin
      checkOutput("weightOut", 32'(weightOut), 32'(expOut));
    end
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doWrite(input int kern, input int pix, input int data);
    applyStimulus(0, 1, 1, 0, 0, 0, kern, pix, data);
  endtask

  task automatic doRead(input int kern, input int pix);
    applyStimulus(0, 1, 0, 1, 0, 0, kern, pix, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      refMem[i]     = 8'd0;
      refWritten[i] = 0;
    end
    refMaps     = 0;
    refPix      = 0;
    expOut      = 8'd0;
    expOutKnown = 0;

    // Reset, then confirm every weight read errors while nothing is written.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 0);
    doRead(0, 0);
    checkOutput("errAfterReset", 32'(readErr), 32'd1);
    idleCycle();

    // Write then immediately read the same word.
    doWrite(3, 10, 8'hA5);
    doRead(3, 10);
    checkOutput("rawData", 32'(weightOut), 32'hA5);
    idleCycle();

    // Corner writes fill the extents to 16 kernels by 64 pixels.
    doWrite(0, 0, 8'h11);
    doWrite(15, 63, 8'h22);
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("numMaps16", 32'(weightOut), 32'd16);
    applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("numPix64", 32'(weightOut), 32'd64);
    doRead(15, 63);
    checkOutput("cornerData", 32'(weightOut), 32'h22);

    // Small extent: only kernels 0..1, pixels 0..7.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 8; p++) begin
        doWrite(k, p, 16 * k + p + 1);
      end
    end
    doRead(2, 0);
    checkOutput("oobKernErr", 32'(readErr), 32'd1);
    doRead(1, 8);
    checkOutput("oobPixErr", 32'(readErr), 32'd1);
    doRead(1, 7);

    // Write wins over a simultaneous read; disabled reads are ignored.
    applyStimulus(0, 1, 1, 1, 0, 0, 1, 3, 8'h5C);
    applyStimulus(0, 0, 0, 1, 1, 1, 1, 3, 0);
    idleCycle();

    // Four back-to-back reads.
    doRead(0, 0);
    doRead(1, 3);
    doRead(0, 7);
    doRead(1, 1);
    idleCycle();

    // Reset right after a read kills the pending response and the extents.
    doRead(0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("mapsAfterReset", 32'(weightOut), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bit rst;
      bit en;
      int kern;
      int pix;
      rst  = ($urandom % 60) == 0;
      en   = ($urandom % 8) != 0;
      kern = ($urandom % 4 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 5);
      pix  = ($urandom % 4 == 0) ? $urandom_range(0, 63) : $urandom_range(0, 11);
      applyStimulus(rst, en, ($urandom % 10) < 3, ($urandom % 10) < 5,
                    ($urandom % 10) < 2, ($urandom % 10) < 2,
                    kern, pix, $urandom_range(0, 255));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
